reg_file_sb: RTL
================

# reg_file_sb

Parametrised integer register file with a load-writeback scoreboard, replacing the fixed 32×32, two-read, one-write register file in the core datapath. Provides NRD combinational read ports, a primary (ALU) write port and a late (load) write port, and tracks registers awaiting a load result with per-register busy bits, an outstanding-load counter and a sticky protocol-error flag. Sits between decode (reads, busy checks, load issue) and writeback (both write ports).

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥4)
- NRD, 2, number of read ports (≥1)
- AW, $clog2(NREGS), derived register-address width, not overridden
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- rs_addr  in  NRD*AW  packed read addresses, port i at [i*AW +: AW]
- rs_data  out  NRD*XLEN  packed read data
- rs_busy  out  NRD  busy bit of each addressed register
- RegWEn  in  1  primary write enable
- rd  in  AW  primary write address
- Writedata  in  XLEN  primary write data
- lw_en  in  1  late (load) writeback enable; clears busy
- lw_rd  in  AW  late write address
- lw_data  in  XLEN  late write data
- mark_en  in  1  load issue: set busy for mark_rd
- mark_rd  in  AW  register to mark busy
- pend_cnt  out  AW  number of registers currently busy
- sb_err  out  1  sticky scoreboard protocol error

## Operation
- Register 0 hardwired: reads return 0, rs_busy 0; writes, marks and writebacks to it ignored (no busy/count/error effect).
- Reads combinational: rs_data[i] = reg[rs_addr[i]], rs_busy[i] = busy[rs_addr[i]].
- Writes: RegWEn writes Writedata to rd; lw_en writes lw_data to lw_rd. Both to same nonzero address same cycle: Writedata stored (primary is younger).
- Busy: mark_en sets busy[mark_rd]; lw_en clears busy[lw_rd]; RegWEn never changes busy.
- mark_en and lw_en same nonzero register same cycle: busy stays 1, pend_cnt unchanged, no error.
- pend_cnt = population of busy bits, maintained incrementally: +1 on valid set of clear bit, −1 on valid clear of set bit, net per cycle.
- sb_err set (and held until rst) when: mark_en on already-busy register (busy/count unchanged), or lw_en on non-busy register (data still written).

## Timing
- Reset: all registers 0, all busy 0, pend_cnt 0, sb_err 0; rs_data reads 0 while rst high.
- rst asserted mid-operation clears everything immediately; writes/marks in that cycle lost.
- Write latency 1: data written at edge N readable after edge N (without bypass).
- Busy set by mark at edge N visible on rs_busy after edge N; cleared by lw at edge N likewise.
- pend_cnt and sb_err registered, update at the same edge as busy.

## Configuration
- REGFILE_BYPASS_EN defined: read port whose nonzero address matches an active write in the same cycle returns the write data combinationally (primary over late), and rs_busy reads 0 when lw_en targets that register.
- Not defined: reads return pre-edge contents; new value and busy clear visible next cycle.

## Structure
- Package regfile_pkg: XLEN and NREGS defaults, ZERO_REG constant, reg-address typedef.
- Sub-module reg_scoreboard: busy vector, pend_cnt counter, sb_err; the top holds the data array, write arbitration and bypass mux.

## Test plan
- Reset then read all 32 registers on both ports -> all 0, pend_cnt 0, sb_err 0.
- RegWEn=1, rd=5, Writedata=0xDEADBEEF; next cycle rs_addr[0]=5 -> 0xDEADBEEF; write to x0 with 0x1234 -> x0 still reads 0.
- mark x7, mark x9 -> pend_cnt 2, rs_busy for x7 =1; lw_en x7 data 0x55 -> x7 reads 0x55, busy 0, pend_cnt 1.
- Same cycle RegWEn rd=3 data 0xAA and lw_en lw_rd=3 data 0xBB (x3 busy) -> x3 reads 0xAA, busy cleared, pend_cnt decrements.
- mark x4 twice -> sb_err 1, pend_cnt 1; lw_en on non-busy x6 -> sb_err stays 1, x6 written; rst pulse mid-sequence -> all state 0.
- With REGFILE_BYPASS_EN: RegWEn rd=8 data 0x77 while rs_addr[1]=8 -> rs_data same cycle 0x77; without macro -> old value, 0x77 next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared defaults and types for the scoreboarded register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned NREGS_DEFAULT = 32;
    localparam int unsigned NRD_DEFAULT   = 2;
    localparam int unsigned ZERO_REG      = 0;

    typedef logic [$clog2(NREGS_DEFAULT)-1:0] reg_addr_t;

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ============================================================================
// Module      : reg_scoreboard
// Description : Per-register load-pending bits, pending counter and sticky
//               protocol-error flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mark_en,
    input  logic [AW-1:0]    mark_rd,
    input  logic             lw_en,
    input  logic [AW-1:0]    lw_rd,
    output logic [NREGS-1:0] busy,
    output logic [AW-1:0]    pend_cnt,
    output logic             sb_err
);

    localparam logic [AW-1:0] C_ONE  = AW'(1);
    localparam logic [AW-1:0] C_ZERO = AW'(ZERO_REG);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW-1:0]    pend_cnt_q, pend_cnt_d;
    logic             sb_err_q, sb_err_d;
    logic             w_mark_vld, w_lw_vld, w_collide;

    always_comb begin
        w_mark_vld = mark_en && (mark_rd != C_ZERO);
        w_lw_vld   = lw_en && (lw_rd != C_ZERO);
        w_collide  = w_mark_vld && w_lw_vld && (mark_rd == lw_rd);
        busy_d     = busy_q;
        pend_cnt_d = pend_cnt_q;
        sb_err_d   = sb_err_q;

        // Load returning while the next load to the same register issues:
        // the register simply stays pending.
        if (w_collide) begin
            if (!busy_q[mark_rd]) begin
                pend_cnt_d = pend_cnt_q + C_ONE;
            end
            busy_d[mark_rd] = 1'b1;
        end else begin
            if (w_lw_vld) begin
                if (busy_q[lw_rd]) begin
                    busy_d[lw_rd] = 1'b0;
                    pend_cnt_d    = pend_cnt_d - C_ONE;
                end else begin
                    sb_err_d = 1'b1;
                end
            end
            if (w_mark_vld) begin
                if (busy_q[mark_rd]) begin
                    sb_err_d = 1'b1;
                end else begin
                    busy_d[mark_rd] = 1'b1;
                    pend_cnt_d      = pend_cnt_d + C_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            pend_cnt_q <= '0;
            sb_err_q   <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            pend_cnt_q <= pend_cnt_d;
            sb_err_q   <= sb_err_d;
        end
    end

    assign busy     = busy_q;
    assign pend_cnt = pend_cnt_q;
    assign sb_err   = sb_err_q;

endmodule : reg_scoreboard

`default_nettype wire

// File: rtl/reg_file_sb.sv
// ============================================================================
// Module      : reg_file_sb
// Description : Parametrised register file with primary and late write ports
//               and a load scoreboard. Optional same-cycle write-to-read
//               bypass enabled by defining REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_sb
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NRD   = NRD_DEFAULT,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic                RegWEn,
    input  logic [AW-1:0]       rd,
    input  logic [XLEN-1:0]     Writedata,
    input  logic                lw_en,
    input  logic [AW-1:0]       lw_rd,
    input  logic [XLEN-1:0]     lw_data,
    input  logic                mark_en,
    input  logic [AW-1:0]       mark_rd,
    output logic [AW-1:0]       pend_cnt,
    output logic                sb_err
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] w_busy;

    reg_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .mark_en  (mark_en),
        .mark_rd  (mark_rd),
        .lw_en    (lw_en),
        .lw_rd    (lw_rd),
        .busy     (w_busy),
        .pend_cnt (pend_cnt),
        .sb_err   (sb_err)
    );

    // Primary write applied last so it wins over a same-address load return.
    always_comb begin
        regs_d = regs_q;
        if (lw_en) begin
            regs_d[lw_rd] = lw_data;
        end
        if (RegWEn) begin
            regs_d[rd] = Writedata;
        end
        regs_d[ZERO_REG] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_rdata;
        logic            w_rbusy;

        assign w_addr = rs_addr[i*AW +: AW];

        always_comb begin
            w_rdata = regs_q[w_addr];
            w_rbusy = w_busy[w_addr];
`ifdef REGFILE_BYPASS_EN
            if (!rst && (w_addr != AW'(ZERO_REG))) begin
                if (lw_en && (lw_rd == w_addr)) begin
                    w_rdata = lw_data;
                    w_rbusy = 1'b0;
                end
                if (RegWEn && (rd == w_addr)) begin
                    w_rdata = Writedata;
                end
            end
`endif
        end

        assign rs_data[i*XLEN +: XLEN] = w_rdata;
        assign rs_busy[i]              = w_rbusy;
    end : g_rd

endmodule : reg_file_sb

`default_nettype wire
